// File: rtl/sdram_bist_engine.sv
// SDRAM power-on self-test: fills DEPTH bursts with a generated pattern, reads them
// back, compares against the regenerated pattern and reports errors and progress.
module sdram_bist_engine #(
    parameter int ADDR_W  = 24,
    parameter int DATA_W  = 16,
    parameter int WORDS   = 4,
    parameter int DEPTH   = 386400,
    parameter int BAR_MAX = 799,
    parameter int BAR_DIV = 966,
    parameter int TIMEOUT = 4096
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [1:0]                i_mode,
    input  logic                      i_stop_on_err,
    output logic                      o_wr_req,
    output logic [ADDR_W-1:0]         o_wr_addr,
    output logic [WORDS*DATA_W-1:0]   o_wr_data,
    input  logic                      i_wr_done,
    output logic                      o_rd_req,
    output logic [ADDR_W-1:0]         o_rd_addr,
    input  logic [WORDS*DATA_W-1:0]   i_rd_data,
    input  logic                      i_rd_done,
    output logic [11:0]               o_bar_value,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_pass,
    output logic                      o_timeout,
    output logic [15:0]               o_err_cnt,
    output logic [ADDR_W-1:0]         o_first_err_addr,
    output logic                      o_first_err_valid
);
    localparam int BURST_W = WORDS * DATA_W;
    localparam int TMR_W   = $clog2(TIMEOUT + 1);
    localparam int STEP_W  = $clog2(BAR_DIV + 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(BAR_DIV - 1);
    localparam logic [11:0]       BAR_TOP   = 12'(BAR_MAX);

    typedef enum logic [3:0] {
        IDLE, WR, WR_WAIT, NEXT_W, RD, RD_WAIT, CMP, NEXT_R, DONE
    } state_t;

    state_t              state, state_next;
    logic [ADDR_W-1:0]   addr;
    logic [TMR_W-1:0]    timer;
    logic [STEP_W-1:0]   step;
    logic [1:0]          mode_q;
    logic [BURST_W-1:0]  rd_data_q;
    logic                wr_ack, rd_ack, tmo_hit, last, mismatch, pass_next;

    function automatic logic [DATA_W-1:0] pat_word(input logic [1:0] mode,
                                                   input logic [ADDR_W-1:0] a, input int k);
        logic [DATA_W-1:0] inc;
        int                sh;
        inc = DATA_W'(a) * DATA_W'(WORDS) + DATA_W'(k);
        sh  = (int'(a) + k) % DATA_W;
        case (mode)
            2'd0:    return inc;
            2'd1:    return (a[0] ^ k[0]) ? DATA_W'({(DATA_W/2+1){2'b01}})
                                          : DATA_W'({(DATA_W/2+1){2'b10}});
            2'd2:    return DATA_W'(1) << sh;
            default: return ~inc;
        endcase
    endfunction

    function automatic logic [BURST_W-1:0] burst(input logic [1:0] mode, input logic [ADDR_W-1:0] a);
        logic [BURST_W-1:0] b;
        b = '0;
        for (int k = 0; k < WORDS; k++) b[k*DATA_W +: DATA_W] = pat_word(mode, a, k);
        return b;
    endfunction

    function automatic logic [15:0] sat_err(input logic [15:0] x);
        return (x == 16'hFFFF) ? x : x + 16'd1;
    endfunction

    function automatic logic [11:0] sat_bar(input logic [11:0] x);
        return (x >= BAR_TOP) ? BAR_TOP : x + 12'd1;
    endfunction

    // Only the done matching the active request is accepted; stray dones are ignored.
    assign wr_ack    = (state == WR_WAIT) && o_wr_req && i_wr_done;
    assign rd_ack    = (state == RD_WAIT) && o_rd_req && i_rd_done;
    assign tmo_hit   = (((state == WR_WAIT) && !wr_ack) || ((state == RD_WAIT) && !rd_ack))
                       && (timer == TMR_LAST);
    assign last      = (addr == ADDR_LAST);
    assign mismatch  = (state == CMP) && (rd_data_q != burst(mode_q, o_rd_addr));
    assign pass_next = (o_err_cnt == 16'd0) && !mismatch && !tmo_hit && !o_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = WR;
            WR:      state_next = WR_WAIT;
            WR_WAIT: if (wr_ack) state_next = NEXT_W; else if (tmo_hit) state_next = DONE;
            NEXT_W:  state_next = last ? RD : WR;
            RD:      state_next = RD_WAIT;
            RD_WAIT: if (rd_ack) state_next = CMP; else if (tmo_hit) state_next = DONE;
            CMP:     state_next = (mismatch && i_stop_on_err) ? DONE : NEXT_R;
            NEXT_R:  state_next = last ? DONE : RD;
            default: state_next = DONE;
        endcase
        if (!en) state_next = IDLE;
    end

    always_comb begin
        o_busy = !((state == IDLE) || (state == DONE));
    end

    // Pattern mode and captured read burst need no reset: both are loaded before use.
    always_ff @(posedge clk) begin
        if (state == IDLE) mode_q <= i_mode;
        if (rd_ack)        rd_data_q <= i_rd_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0; timer <= '0; step <= '0;
            o_wr_req <= 1'b0; o_wr_addr <= '0; o_wr_data <= '0;
            o_rd_req <= 1'b0; o_rd_addr <= '0; o_bar_value <= '0;
            o_done <= 1'b0; o_pass <= 1'b0; o_timeout <= 1'b0; o_err_cnt <= '0;
            o_first_err_addr <= '0; o_first_err_valid <= 1'b0;
        end else if (!en) begin
            addr <= '0; timer <= '0; step <= '0;
            o_wr_req <= 1'b0; o_wr_addr <= '0; o_wr_data <= '0;
            o_rd_req <= 1'b0; o_rd_addr <= '0; o_bar_value <= '0;
            o_done <= 1'b0; o_pass <= 1'b0; o_timeout <= 1'b0; o_err_cnt <= '0;
            o_first_err_addr <= '0; o_first_err_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: addr <= '0;
                WR: begin
                    o_wr_addr <= addr;
                    o_wr_data <= burst(mode_q, addr);
                    o_wr_req  <= 1'b1;
                    timer     <= '0;
                end
                RD: begin
                    o_rd_addr <= addr;
                    o_rd_req  <= 1'b1;
                    timer     <= '0;
                end
                WR_WAIT, RD_WAIT: begin
                    if (wr_ack || rd_ack) begin
                        o_wr_req <= 1'b0;
                        o_rd_req <= 1'b0;
                        if (step == STEP_LAST) begin
                            step        <= '0;
                            o_bar_value <= sat_bar(o_bar_value);
                        end else begin
                            step <= step + 1'b1;
                        end
                    end else if (tmo_hit) begin
                        o_wr_req  <= 1'b0;
                        o_rd_req  <= 1'b0;
                        o_timeout <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                NEXT_W, NEXT_R: addr <= last ? '0 : addr + 1'b1;
                CMP: begin
                    if (mismatch) begin
                        o_err_cnt <= sat_err(o_err_cnt);
                        if (!o_first_err_valid) begin
                            o_first_err_addr  <= o_rd_addr;
                            o_first_err_valid <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
            // A passing run snaps the bar to full; failures keep the value reached.
            if ((state != DONE) && (state_next == DONE)) begin
                o_done <= 1'b1;
                o_pass <= pass_next;
                if (pass_next) o_bar_value <= BAR_TOP;
            end
        end
    end
endmodule

// File: tb/tb_sdram_bist_engine.sv
// Directed bench for sdram_bist_engine: table of full runs against a small memory
// model, plus hand sequences for abort, async reset and timeout corners.
module tb_sdram_bist_engine;
    logic        clk = 1'b0;
    logic        rst_n, en, i_stop_on_err;
    logic [1:0]  i_mode;
    logic        o_wr_req, i_wr_done, o_rd_req, i_rd_done;
    logic [23:0] o_wr_addr, o_rd_addr, o_first_err_addr;
    logic [63:0] o_wr_data, i_rd_data;
    logic [11:0] o_bar_value;
    logic        o_busy, o_done, o_pass, o_timeout, o_first_err_valid;
    logic [15:0] o_err_cnt;

    int total = 0;
    int bad   = 0;

    // memory model configuration (written by the test) and state (written by the model)
    int          hold_len, wr_stall, rd_stall;
    bit          fault;
    logic [63:0] mem [16];
    bit          rd_seen [16];
    int          wr_hold, rd_hold, rd3_cycles;

    typedef struct {
        logic [1:0]  mode;
        bit          stop;
        bit          fault;
        int          rd_stall;
        int          hold;
        int          exp_err;
        bit          exp_fv;
        int          exp_fa;
        bit          exp_pass;
        int          exp_bar;
        bit          exp_tmo;
        int          chk_addr;
        logic [63:0] chk_burst;
    } vec_t;
    vec_t vecs [7];

    sdram_bist_engine #(
        .ADDR_W(24), .DATA_W(16), .WORDS(4), .DEPTH(16),
        .BAR_MAX(7), .BAR_DIV(4), .TIMEOUT(32)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .i_mode(i_mode), .i_stop_on_err(i_stop_on_err),
        .o_wr_req(o_wr_req), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .i_wr_done(i_wr_done),
        .o_rd_req(o_rd_req), .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data), .i_rd_done(i_rd_done),
        .o_bar_value(o_bar_value), .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass),
        .o_timeout(o_timeout), .o_err_cnt(o_err_cnt), .o_first_err_addr(o_first_err_addr),
        .o_first_err_valid(o_first_err_valid)
    );

    always #5 clk = ~clk;

    // Memory model: answers a request with a done held hold_len cycles, honours stall addresses.
    always @(negedge clk) begin
        if (!en || !rst_n) begin
            i_wr_done = 1'b0; i_rd_done = 1'b0; i_rd_data = '0;
            wr_hold = 0; rd_hold = 0; rd3_cycles = 0;
            for (int i = 0; i < 16; i++) begin mem[i] = '0; rd_seen[i] = 1'b0; end
        end else begin
            if (wr_hold > 0) wr_hold--;
            else begin
                i_wr_done = 1'b0;
                if (o_wr_req && int'(o_wr_addr) != wr_stall) begin
                    mem[o_wr_addr[3:0]] = o_wr_data;
                    i_wr_done = 1'b1;
                    wr_hold = hold_len - 1;
                end
            end
            if (o_rd_req && o_rd_addr == 24'd3) rd3_cycles++;
            if (rd_hold > 0) rd_hold--;
            else begin
                i_rd_done = 1'b0;
                i_rd_data = {$urandom, $urandom};
                if (o_rd_req) rd_seen[o_rd_addr[3:0]] = 1'b1;
                if (o_rd_req && int'(o_rd_addr) != rd_stall) begin
                    i_rd_data = mem[o_rd_addr[3:0]];
                    if (fault && (o_rd_addr == 24'd9 || o_rd_addr == 24'd12))
                        i_rd_data[32] = ~i_rd_data[32];
                    i_rd_done = 1'b1;
                    rd_hold = hold_len - 1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!o_done && n < 2000) begin @(negedge clk); n++; end
        check(name, 64'(o_done), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   n;
        rst_n = 1'b0; en = 1'b0; i_mode = 2'd0; i_stop_on_err = 1'b0;
        hold_len = 1; fault = 1'b0; wr_stall = -1; rd_stall = -1;

        //          mode stop flt stall hold err fv fa pass bar tmo addr burst
        vecs[0] = '{2'd0, 0, 0, -1, 1, 0, 0, 0, 1, 7, 0, 5, 64'h0017_0016_0015_0014};
        vecs[1] = '{2'd0, 0, 1, -1, 1, 2, 1, 9, 0, 7, 0, 5, 64'h0017_0016_0015_0014};
        vecs[2] = '{2'd0, 1, 1, -1, 1, 1, 1, 9, 0, 6, 0, 0, 64'h0003_0002_0001_0000};
        vecs[3] = '{2'd0, 0, 0,  3, 1, 0, 0, 0, 0, 4, 1, 1, 64'h0007_0006_0005_0004};
        vecs[4] = '{2'd1, 0, 0, -1, 3, 0, 0, 0, 1, 7, 0, 0, 64'h5555_AAAA_5555_AAAA};
        vecs[5] = '{2'd2, 0, 0, -1, 1, 0, 0, 0, 1, 7, 0, 3, 64'h0040_0020_0010_0008};
        vecs[6] = '{2'd3, 0, 0, -1, 1, 0, 0, 0, 1, 7, 0, 0, 64'hFFFC_FFFD_FFFE_FFFF};

        repeat (3) @(negedge clk);
        check("rst wr_req", 64'(o_wr_req), 64'd0);
        check("rst rd_req", 64'(o_rd_req), 64'd0);
        check("rst busy",   64'(o_busy),   64'd0);
        check("rst done",   64'(o_done),   64'd0);
        check("rst bar",    64'(o_bar_value), 64'd0);
        check("rst err",    64'(o_err_cnt),   64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle busy", 64'(o_busy), 64'd0);

        for (int i = 0; i < 7; i++) begin
            v = vecs[i];
            i_mode = v.mode; i_stop_on_err = v.stop; fault = v.fault;
            rd_stall = v.rd_stall; hold_len = v.hold;
            en = 1'b0;
            repeat (2) @(negedge clk);
            en = 1'b1;
            @(negedge clk);
            i_mode = ~v.mode;
            wait_done($sformatf("r%0d done", i));
            check($sformatf("r%0d err", i),   64'(o_err_cnt), 64'(v.exp_err));
            check($sformatf("r%0d fv", i),    64'(o_first_err_valid), 64'(v.exp_fv));
            check($sformatf("r%0d pass", i),  64'(o_pass), 64'(v.exp_pass));
            check($sformatf("r%0d bar", i),   64'(o_bar_value), 64'(v.exp_bar));
            check($sformatf("r%0d tmo", i),   64'(o_timeout), 64'(v.exp_tmo));
            check($sformatf("r%0d busy", i),  64'(o_busy), 64'd0);
            check($sformatf("r%0d burst", i), mem[v.chk_addr], v.chk_burst);
            if (v.exp_fv) check($sformatf("r%0d fa", i), 64'(o_first_err_addr), 64'(v.exp_fa));
            if (v.stop) begin
                check("stop rd addr9 seen", 64'(rd_seen[9]), 64'd1);
                check("stop no rd addr10", 64'(rd_seen[10]), 64'd0);
            end
            if (v.rd_stall == 3) begin
                check("tmo req cycles", 64'(rd3_cycles), 64'd32);
                check("tmo rd_req low", 64'(o_rd_req), 64'd0);
            end
            repeat (3) @(negedge clk);
            check($sformatf("r%0d done held", i), 64'(o_done), 64'd1);
        end

        // abort while a write is outstanding, then restart from address 0
        en = 1'b0; rd_stall = -1; fault = 1'b0; hold_len = 1; wr_stall = 7;
        i_mode = 2'd0; i_stop_on_err = 1'b0;
        repeat (2) @(negedge clk);
        check("en0 done cleared", 64'(o_done), 64'd0);
        en = 1'b1;
        n = 0;
        while (!(o_wr_req && o_wr_addr == 24'd7) && n < 500) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        check("stall wr_req held", 64'(o_wr_req), 64'd1);
        check("stall wr_addr",     64'(o_wr_addr), 64'd7);
        check("stall bar",         64'(o_bar_value), 64'd1);
        en = 1'b0;
        @(negedge clk);
        check("abort wr_req",  64'(o_wr_req), 64'd0);
        check("abort busy",    64'(o_busy), 64'd0);
        check("abort wr_addr", 64'(o_wr_addr), 64'd0);
        check("abort wr_data", o_wr_data, 64'd0);
        check("abort bar",     64'(o_bar_value), 64'd0);
        wr_stall = -1;
        en = 1'b1;
        n = 0;
        while (!o_wr_req && n < 50) begin @(negedge clk); n++; end
        check("restart wr_addr", 64'(o_wr_addr), 64'd0);
        check("restart wr_data", o_wr_data, 64'h0003_0002_0001_0000);

        // asynchronous reset in the middle of the read phase
        n = 0;
        while (!o_rd_req && n < 500) begin @(negedge clk); n++; end
        check("pre-rst rd_req", 64'(o_rd_req), 64'd1);
        check("pre-rst bar", 64'(o_bar_value), 64'd4);
        rst_n = 1'b0;
        #1;
        check("async rst rd_req", 64'(o_rd_req), 64'd0);
        check("async rst busy",   64'(o_busy), 64'd0);
        check("async rst bar",    64'(o_bar_value), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (!o_wr_req && n < 50) begin @(negedge clk); n++; end
        check("post-rst wr_req",  64'(o_wr_req), 64'd1);
        check("post-rst wr_addr", 64'(o_wr_addr), 64'd0);
        en = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
